// File: rtl/slave_in.sv
// slave_in: slave-side receive port of the serial system bus.
// Deserialises the LSB-first address/burst header and write data, answers the
// slave_ready / rx_done handshake, and emits per-byte memory write strobes or a
// single read-request pulse.
// Optional build macro SLAVE_IN_PARITY_EN: each data beat carries a trailing
// even-parity bit; a bad beat is not written and sets err.
module slave_in #(
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 8,
    parameter int BURST_W = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              slave_sel,
    input  logic              master_valid,
    input  logic              write_en,
    input  logic              read_en,
    input  logic              tx_done,
    input  logic              rx_address,
    input  logic              rx_burst_number,
    input  logic              rx_data,
    input  logic              mem_busy,
    output logic              slave_ready,
    output logic              rx_done,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              rd_req,
    output logic [BURST_W-1:0] rd_burst,
    output logic              err
);

`ifdef SLAVE_IN_PARITY_EN
    localparam int BEAT_BITS = DATA_W + 1;
`else
    localparam int BEAT_BITS = DATA_W;
`endif
    localparam int HCW = $clog2(ADDR_W + 1);
    localparam int DCW = $clog2(BEAT_BITS + 1);
    localparam logic [HCW-1:0] HDR_LAST  = HCW'(ADDR_W - 1);
    localparam logic [HCW-1:0] BURST_LIM = HCW'(BURST_W);
    localparam logic [DCW-1:0] BIT_LAST  = DCW'(BEAT_BITS - 1);

    typedef enum logic [1:0] {IDLE, HEADER, DATA, DONE} state_t;

    state_t              state, state_nx;
    logic                accept;
    logic                start;
    logic                op_write;
    logic [HCW-1:0]      hdr_cnt;
    logic [DCW-1:0]      bit_cnt;
    logic [BURST_W-1:0]  beat;
    logic [ADDR_W-1:0]   addr_sh, addr_nx;
    logic [BURST_W-1:0]  burst_sh, burst_nx, burst_upd;
    logic [DATA_W-1:0]   byte_sh, byte_nx;
    logic                burst_take;
    logic                hdr_last, bit_last, last_beat;

    assign accept     = slave_sel & master_valid & slave_ready;
    assign start      = accept & (write_en ^ read_en);
    assign addr_nx    = {rx_address, addr_sh[ADDR_W-1:1]};
    assign burst_nx   = {rx_burst_number, burst_sh[BURST_W-1:1]};
    assign byte_nx    = {rx_data, byte_sh[DATA_W-1:1]};
    // The IDLE bit is header bit 0, so it always feeds the burst register.
    assign burst_take = (state == IDLE) || (hdr_cnt < BURST_LIM);
    assign burst_upd  = burst_take ? burst_nx : burst_sh;
    assign hdr_last   = (hdr_cnt == HDR_LAST);
    assign bit_last   = (bit_cnt == BIT_LAST);
    assign last_beat  = (beat == burst_sh);
    assign rx_done    = (state == DONE);

    // Ready depends only on state and memory backpressure, never on accept.
    always_comb begin
        slave_ready = 1'b0;
        case (state)
            IDLE, HEADER: slave_ready = 1'b1;
            DATA:         slave_ready = !mem_busy;
            default:      slave_ready = 1'b0;
        endcase
        if (reset) slave_ready = 1'b0;
    end

    // Frame state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Next-state selection; abort wins over a bit accepted in the same cycle.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (start) state_nx = HEADER;
            end
            HEADER: begin
                if (tx_done)
                    state_nx = IDLE;
                else if (accept && hdr_last)
                    state_nx = op_write ? DATA : DONE;
            end
            DATA: begin
                if (tx_done)
                    state_nx = IDLE;
                else if (accept && bit_last && last_beat)
                    state_nx = DONE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Header/data shifting, beat counting and registered output strobes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_write  <= 1'b0;
            hdr_cnt   <= '0;
            bit_cnt   <= '0;
            beat      <= '0;
            addr_sh   <= '0;
            burst_sh  <= '0;
            byte_sh   <= '0;
            mem_wr_en <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rd_req    <= 1'b0;
            rd_burst  <= '0;
            err       <= 1'b0;
        end else begin
            mem_wr_en <= 1'b0;
            rd_req    <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        op_write <= write_en;
                        addr_sh  <= addr_nx;
                        burst_sh <= burst_nx;
                        hdr_cnt  <= HCW'(1);
                    end
                end
                HEADER: begin
                    if (tx_done) begin
                        err <= 1'b1;
                    end else if (accept) begin
                        addr_sh <= addr_nx;
                        if (burst_take) burst_sh <= burst_nx;
                        hdr_cnt <= hdr_cnt + 1'b1;
                        if (hdr_last) begin
                            bit_cnt <= '0;
                            beat    <= '0;
                            if (!op_write) begin
                                rd_req   <= 1'b1;
                                mem_addr <= addr_nx;
                                rd_burst <= burst_upd;
                            end
                        end
                    end
                end
                DATA: begin
                    if (tx_done) begin
                        err <= 1'b1;
                    end else if (accept) begin
                        if (bit_last) begin
                            bit_cnt <= '0;
                            beat    <= beat + 1'b1;
`ifdef SLAVE_IN_PARITY_EN
                            // Final bit is the parity bit; the byte is already complete.
                            if (^{byte_sh, rx_data}) begin
                                err <= 1'b1;
                            end else begin
                                mem_wr_en <= 1'b1;
                                mem_wdata <= byte_sh;
                                mem_addr  <= addr_sh + ADDR_W'(beat);
                            end
`else
                            mem_wr_en <= 1'b1;
                            mem_wdata <= byte_nx;
                            mem_addr  <= addr_sh + ADDR_W'(beat);
`endif
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            byte_sh <= byte_nx;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_slave_in.sv
// tb_slave_in: self-checking bench for slave_in (default and SLAVE_IN_PARITY_EN builds).
module tb_slave_in;

    localparam int ADDR_W  = 12;
    localparam int DATA_W  = 8;
    localparam int BURST_W = 12;
`ifdef SLAVE_IN_PARITY_EN
    localparam int BB = DATA_W + 1;
`else
    localparam int BB = DATA_W;
`endif

    logic clk = 1'b0;
    logic reset, slave_sel, master_valid, write_en, read_en, tx_done;
    logic rx_address, rx_burst_number, rx_data, mem_busy;
    logic slave_ready, rx_done, mem_wr_en, rd_req, err;
    logic [ADDR_W-1:0]  mem_addr;
    logic [DATA_W-1:0]  mem_wdata;
    logic [BURST_W-1:0] rd_burst;

    slave_in #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_W(BURST_W)) dut (
        .clk(clk), .reset(reset), .slave_sel(slave_sel), .master_valid(master_valid),
        .write_en(write_en), .read_en(read_en), .tx_done(tx_done),
        .rx_address(rx_address), .rx_burst_number(rx_burst_number), .rx_data(rx_data),
        .mem_busy(mem_busy), .slave_ready(slave_ready), .rx_done(rx_done),
        .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .rd_req(rd_req), .rd_burst(rd_burst), .err(err)
    );

    always #5 clk = ~clk;

    int cyc;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [ADDR_W-1:0] a; logic [DATA_W-1:0] d; } wr_ev_t;
    wr_ev_t             wq[$];
    int                 done_q[$];
    int                 rd_cyc_q[$];
    logic [ADDR_W-1:0]  rd_a_q[$];
    logic [BURST_W-1:0] rd_b_q[$];

    // Observe registered outputs mid-cycle.
    always @(negedge clk) begin
        if (mem_wr_en === 1'b1) wq.push_back('{mem_addr, mem_wdata});
        if (rx_done === 1'b1) done_q.push_back(cyc);
        if (rd_req === 1'b1) begin
            rd_cyc_q.push_back(cyc);
            rd_a_q.push_back(mem_addr);
            rd_b_q.push_back(rd_burst);
        end
    end

    int checks = 0;
    int errors = 0;
    bit exp_err = 1'b0;
    logic [DATA_W-1:0] frame_bytes[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_ready"}, 32'(slave_ready), 32'd0);
        chk({tag, "_rx_done"}, 32'(rx_done), 32'd0);
        chk({tag, "_wr_en"}, 32'(mem_wr_en), 32'd0);
        chk({tag, "_addr"}, 32'(mem_addr), 32'd0);
        chk({tag, "_wdata"}, 32'(mem_wdata), 32'd0);
        chk({tag, "_rd_req"}, 32'(rd_req), 32'd0);
        chk({tag, "_rd_burst"}, 32'(rd_burst), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
    endtask

    // Drives one frame bit by bit and checks it against the frame-level model.
    task automatic run_frame(input bit wr, input bit rd, input logic [ADDR_W-1:0] addr,
                             input logic [BURST_W-1:0] burst, input int busy_at,
                             input int busy_len, input int cut_at, input bit cut_rst,
                             input bit gaps);
        bit sa[$], sb[$], sd[$];
        logic [DATA_W-1:0] bytes[$];
        logic [DATA_W-1:0] bv;
        logic [ADDR_W-1:0] ea;
        int nbits, idx, stalls, t0, guard, busy_left, n_wr, n_done, n_rd;
        bit legal, busy, valid, sel, data_phase, acc, busy_started;

        legal = wr ^ rd;
        for (int i = 0; i < ADDR_W; i++) begin
            sa.push_back(addr[i]);
            sb.push_back(i < BURST_W ? burst[i] : 1'($urandom));
            sd.push_back(1'($urandom));
        end
        if (wr) begin
            for (int b = 0; b <= int'(burst); b++) begin
                bv = (b < frame_bytes.size()) ? frame_bytes[b] : DATA_W'($urandom);
                bytes.push_back(bv);
                for (int j = 0; j < BB; j++) begin
                    sd.push_back(j < DATA_W ? bv[j] : ^bv);
                    sa.push_back(1'($urandom));
                    sb.push_back(1'($urandom));
                end
            end
        end
        frame_bytes.delete();
        nbits = sa.size();
        wq.delete(); done_q.delete(); rd_cyc_q.delete(); rd_a_q.delete(); rd_b_q.delete();

        idx = 0; stalls = 0; t0 = -1; guard = 0; busy_left = 0; busy_started = 0;
        while (idx < nbits) begin
            @(negedge clk);
            guard++;
            if (guard > 5000) begin
                chk("frame_timeout", 32'(idx), 32'(nbits));
                break;
            end
            if (idx == cut_at) begin
                if (cut_rst) begin
                    reset = 1'b1; master_valid = 1'b0;
                    #1;
                    check_zero("reset_mid");
                    @(negedge clk);
                    reset = 1'b0;
                    exp_err = 1'b0;
                end else begin
                    tx_done = 1'b1; master_valid = 1'b0; mem_busy = 1'b0;
                    if (legal) exp_err = 1'b1;
                    @(negedge clk);
                    tx_done = 1'b0; mem_busy = 1'b1;
                    #1;
                    chk("idle_after_abort", 32'(slave_ready), 32'd1);
                    mem_busy = 1'b0;
                end
                break;
            end
            if (busy_at >= 0 && idx == busy_at && !busy_started) begin
                busy_left = busy_len;
                busy_started = 1'b1;
            end
            busy = (busy_left > 0) || (gaps && $urandom_range(0, 4) == 0);
            if (busy_left > 0) busy_left--;
            valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            sel   = gaps ? ($urandom_range(0, 5) != 0) : 1'b1;
            slave_sel = sel; master_valid = valid; write_en = wr; read_en = rd;
            rx_address = sa[idx]; rx_burst_number = sb[idx]; rx_data = sd[idx];
            mem_busy = busy;
            data_phase = legal && (idx >= ADDR_W);
            #1;
            chk("ready", 32'(slave_ready), data_phase ? 32'(!busy) : 32'd1);
            acc = valid && sel && !(data_phase && busy);
            if (acc) begin
                if (idx == 0) t0 = cyc;
                idx++;
            end else if (t0 >= 0) begin
                stalls++;
            end
        end
        @(negedge clk);
        master_valid = 1'b0; write_en = 1'b0; read_en = 1'b0; mem_busy = 1'b0; slave_sel = 1'b0;
        repeat (4) @(negedge clk);

        n_wr   = 0;
        n_done = 0;
        n_rd   = 0;
        if (legal && wr) n_wr = (cut_at < 0) ? int'(burst) + 1
                                 : (cut_at >= ADDR_W ? (cut_at - ADDR_W) / BB : 0);
        if (legal && cut_at < 0) n_done = 1;
        if (legal && !wr && cut_at < 0) n_rd = 1;

        chk("wr_count", 32'(wq.size()), 32'(n_wr));
        for (int i = 0; i < n_wr && i < wq.size(); i++) begin
            ea = addr + ADDR_W'(i);
            chk("wr_addr", 32'(wq[i].a), 32'(ea));
            chk("wr_data", 32'(wq[i].d), 32'(bytes[i]));
        end
        chk("done_count", 32'(done_q.size()), 32'(n_done));
        if (n_done == 1 && done_q.size() == 1)
            chk("done_cycle", 32'(done_q[0] - t0), 32'(nbits + stalls));
        chk("rd_count", 32'(rd_cyc_q.size()), 32'(n_rd));
        if (n_rd == 1 && rd_cyc_q.size() == 1) begin
            chk("rd_cycle", 32'(rd_cyc_q[0] - t0), 32'(ADDR_W + stalls));
            chk("rd_addr", 32'(rd_a_q[0]), 32'(addr));
            chk("rd_burst", 32'(rd_b_q[0]), 32'(burst));
        end
        chk("err", 32'(err), 32'(exp_err));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        bit                 w;
        logic [ADDR_W-1:0]  ra;
        logic [BURST_W-1:0] rb;
        int                 nb, cut;

        reset = 1'b1; slave_sel = 1'b0; master_valid = 1'b0; write_en = 1'b0;
        read_en = 1'b0; tx_done = 1'b0; rx_address = 1'b0; rx_burst_number = 1'b0;
        rx_data = 1'b0; mem_busy = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_zero("reset");
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Single-byte write.
        frame_bytes = '{8'h09};
        run_frame(1'b1, 1'b0, 12'h553, 12'd0, -1, 0, -1, 1'b0, 1'b0);
        // Burst crossing the top of the address space.
        frame_bytes = '{8'hA1, 8'hB2, 8'hC3};
        run_frame(1'b1, 1'b0, 12'hFFE, 12'd2, -1, 0, -1, 1'b0, 1'b0);
        // Read request.
        run_frame(1'b0, 1'b1, 12'h123, 12'd5, -1, 0, -1, 1'b0, 1'b0);
        // Memory backpressure for 4 cycles mid-byte.
        frame_bytes = '{8'h6C};
        run_frame(1'b1, 1'b0, 12'h2F0, 12'd0, ADDR_W + 3, 4, -1, 1'b0, 1'b0);
        // Abort after 5 data bits.
        frame_bytes = '{8'h5A};
        run_frame(1'b1, 1'b0, 12'h321, 12'd0, -1, 0, ADDR_W + 5, 1'b0, 1'b0);
        // Illegal op: both enables high, nothing may start.
        run_frame(1'b1, 1'b1, 12'h456, 12'd0, -1, 0, -1, 1'b0, 1'b0);
        // Reset during header, then a clean write.
        run_frame(1'b1, 1'b0, 12'h777, 12'd0, -1, 0, 5, 1'b1, 1'b0);
        frame_bytes = '{8'h55};
        run_frame(1'b1, 1'b0, 12'h0AA, 12'd0, -1, 0, -1, 1'b0, 1'b0);

        // Randomized frames with valid/select gaps, backpressure and occasional aborts.
        for (int n = 0; n < 24; n++) begin
            w  = 1'($urandom_range(0, 1));
            ra = ADDR_W'($urandom);
            rb = w ? BURST_W'($urandom_range(0, 3)) : BURST_W'($urandom);
            nb = ADDR_W + (w ? (int'(rb) + 1) * BB : 0);
            cut = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, nb - 1)) : -1;
            run_frame(w, !w, ra, rb, -1, 0, cut, 1'b0, 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/slave_in.md
Name: slave_in

Overview:
- Slave-side receive port of the serial system bus; the far end of the master transmit port.
- Deserialises the bit-serial address, burst and data lines driven by a bus master.
- Returns the slave_ready / rx_done handshake.
- Turns write frames into per-byte local-memory write strobes and read frames into a single read-request pulse for the slave's read path.

Parameters:
- ADDR_W, 12, address width, serial header length in bits.
- DATA_W, 8, data byte width, bits per data beat.
- BURST_W, 12, burst count width; must be ≤ ADDR_W.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- slave_sel  in  1  this slave selected by the bus decoder.
- master_valid  in  1  master drives a valid bit this cycle.
- write_en  in  1  frame is a write.
- read_en  in  1  frame is a read.
- tx_done  in  1  master abort/end-of-frame indication.
- rx_address  in  1  serial address, LSB first.
- rx_burst_number  in  1  serial burst count, LSB first.
- rx_data  in  1  serial write data, LSB first.
- mem_busy  in  1  local memory cannot accept a write.
- slave_ready  out  1  slave accepts a bit this cycle.
- rx_done  out  1  one-cycle pulse on frame completion.
- mem_wr_en  out  1  one-cycle write strobe.
- mem_addr  out  ADDR_W  write/read address.
- mem_wdata  out  DATA_W  write data.
- rd_req  out  1  one-cycle read-request pulse.
- rd_burst  out  BURST_W  captured burst count for reads.
- err  out  1  sticky frame error.

Behaviour:
- Reset (async): state IDLE; all outputs 0; counters and shift registers 0.
- Bit accept: accept = slave_sel & master_valid & slave_ready; all shifts and counts advance only on accept.
- slave_ready is combinational:
  - 1 in IDLE and HEADER.
  - In DATA, equal to !mem_busy.
  - 0 in DONE and while reset is high.
- IDLE:
  - An accept with write_en^read_en=1 is header bit 0; latch the op and go to HEADER.
  - An accept with write_en=read_en is ignored; stay in IDLE.
- HEADER: ADDR_W bits, counting the IDLE bit as bit 0. Each accept shifts rx_address into the address register and, for the first BURST_W bits, rx_burst_number into the burst register. On the last header bit:
  - Write: go to DATA, beat index 0.
  - Read: next cycle rd_req=1, mem_addr=address, rd_burst=burst, state DONE.
- DATA:
  - DATA_W accepts form one byte from rx_data, LSB first.
  - Cycle after the byte's last bit: mem_wr_en=1, mem_wdata=byte, mem_addr=(address+beat) mod 2^ADDR_W.
  - A burst carries burst_num+1 beats; burst 0 means a single byte.
  - Next-beat bits may be accepted in the same cycle as the mem_wr_en of the previous beat.
  - After the last beat's final bit, go to DONE; that beat's mem_wr_en coincides with DONE.
- DONE: rx_done=1 for one cycle, then IDLE. Latency: first header bit at cycle 0 → rx_done at cycle ADDR_W+(burst+1)·DATA_W for writes, cycle ADDR_W for reads.
- Stall: master_valid=0 or mem_busy=1 freezes bit counters; no timeout.
- Abort: tx_done=1 in HEADER or DATA before completion → IDLE next cycle.
  - The partial beat is discarded, with no mem_wr_en and no rx_done.
  - err is set.
  - A mem_wr_en already due for a completed beat still fires.
- slave_sel dropping mid-frame: only stalls; the frame continues when it returns.
- err clears only on reset.
- mem_addr and mem_wdata hold their last values between strobes.

Optional Feature:
- SLAVE_IN_PARITY_EN defined:
  - Each data beat carries DATA_W+1 bits; the extra last bit on rx_data is even parity over the byte.
  - On mismatch, that beat's mem_wr_en is suppressed and err is set; the frame continues and rx_done still pulses.
  - Write latency becomes ADDR_W+(burst+1)·(DATA_W+1).
- Not defined: no parity bit, err set only by abort.

Test Plan:
- Write: addr 0x553, burst 0, data 0x09, master_valid continuous → mem_wr_en once with mem_addr 0x553, mem_wdata 0x09, rx_done at cycle 20, err 0.
- Burst wrap: addr 0xFFE, burst 2, data 0xA1/0xB2/0xC3 → writes at 0xFFE, 0xFFF, 0x000 with those bytes in order, rx_done at cycle 36.
- Read: read_en=1, addr 0x123, burst 5 → rd_req pulse at cycle 12 with mem_addr 0x123, rd_burst 5, rx_done same cycle, no mem_wr_en.
- Backpressure: mem_busy=1 for 4 cycles mid-byte during a single write → slave_ready 0 for those cycles, byte intact, rx_done delayed by exactly 4 cycles.
- Abort and illegal op:
  - tx_done=1 after 5 data bits → no mem_wr_en, no rx_done, err=1, state IDLE.
  - write_en=read_en=1 → no frame starts.
- Reset mid-frame: reset asserted during HEADER → all outputs 0 immediately; a fresh 0x0AA/0x55 write afterwards completes correctly.
